imem_loader: RTL and testbench

- Hardware writer for the CPU's instruction memory; the CPU instruction fetch is the reader of the same array.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and optionally zero-fills the whole memory first.
- Writes the words sequentially from word 0, then asserts start_o, which drives the CPU start input.
- Sits between the host/boot interface and CPU.Instruction_Memory's write port.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader_wr_stage.sv | 41 ++++
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding, the default geometry and the zero-fill word.
package imem_loader_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    function automatic int depth_of(input int addr_w);
        return 2 ** addr_w;
    endfunction

    localparam int DEPTH = depth_of(DEF_ADDR_W);

    // Also the encoding of a NOP-free cleared slot.
    localparam logic [31:0] ZERO_WORD = 32'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Host-side request/stream bus and instruction-memory write port of the loader.
// The master drives requests and words; the slave (the loader) drives everything else.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              load_req_i;
    logic [ADDR_W:0]   len_i;
    logic              s_valid_i;
    logic [DATA_W-1:0] s_data_i;
    logic              s_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [DATA_W-1:0] imem_data_o;
    logic              start_o;
    logic              busy_o;
    logic              err_o;

    modport master (
        output load_req_i, len_i, s_valid_i, s_data_i,
        input  s_ready_o, imem_we_o, imem_addr_o, imem_data_o, start_o, busy_o, err_o
    );

    modport slave (
        input  load_req_i, len_i, s_valid_i, s_data_i,
        output s_ready_o, imem_we_o, imem_addr_o, imem_data_o, start_o, busy_o, err_o
    );

endinterface

// File: rtl/imem_loader_wr_stage.sv
// Registered write stage: turns the write request chosen this cycle into the
// instruction-memory strobe, address and data presented on the next cycle.
module imem_loader_wr_stage
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we   <= i_wr_en;
            r_addr <= i_wr_addr;
            r_data <= i_wr_data;
        end
    end

    assign o_we   = r_we;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: optionally zero-fills the memory, streams words in
// over valid/ready, writes them from word 0 upward, then raises the CPU start.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter bit FILL_ZERO = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    imem_loader_if.slave bus
);

    localparam int              MEM_DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W + 1)'(MEM_DEPTH - 1);

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   r_len;
    logic              r_err;

    logic              w_idle_like;
    logic              w_req_ok;
    logic              w_req_bad;
    logic              w_ready;
    logic              w_accept;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

    assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
    assign w_req_ok    = w_idle_like && bus.load_req_i && (bus.len_i <= DEPTH_CNT);
    assign w_req_bad   = w_idle_like && bus.load_req_i && (bus.len_i >  DEPTH_CNT);
    assign w_ready     = (r_state == LOAD) && (r_cnt < r_len);
    assign w_accept    = w_ready && bus.s_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_wr_addr    = '0;
        w_wr_data    = DATA_W'(ZERO_WORD);
        unique case (r_state)
            IDLE, DONE: begin
                if (w_req_ok) begin
                    if (FILL_ZERO) begin
                        // Clear word 0 is issued on entry so writes line up with CLEAR cycles.
                        w_next_state = CLEAR;
                        w_wr_en      = 1'b1;
                    end else if (bus.len_i == '0) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = LOAD;
                    end
                end
            end
            CLEAR: begin
                if (r_cnt == LAST_IDX) begin
                    w_next_state = (r_len == '0) ? DONE : LOAD;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_cnt[ADDR_W-1:0] + ADDR_W'(1);
                end
            end
            LOAD: begin
                if (w_accept) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_cnt[ADDR_W-1:0];
                    w_wr_data = bus.s_data_i;
                end
                // Counter reaches len one cycle after the last acceptance, i.e. during its write.
                if (r_cnt == r_len) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_len <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_req_bad;
            if (w_req_ok) begin
                r_len <= bus.len_i;
                r_cnt <= '0;
            end else if (r_state == CLEAR) begin
                r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + (ADDR_W + 1)'(1);
            end else if (w_accept) begin
                r_cnt <= r_cnt + (ADDR_W + 1)'(1);
            end
        end
    end

    imem_loader_wr_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_stage (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .o_we      (bus.imem_we_o),
        .o_addr    (bus.imem_addr_o),
        .o_data    (bus.imem_data_o)
    );

    assign bus.s_ready_o = w_ready;
    assign bus.start_o   = (r_state == DONE);
    assign bus.busy_o    = (r_state == CLEAR) || (r_state == LOAD);
    assign bus.err_o     = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: one zero-filling instance and one plain
// instance share clock and reset; each scenario task checks its own results.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_fz ();
    imem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_nf ();

    imem_loader #(.ADDR_W(AW), .DATA_W(DW), .FILL_ZERO(1'b1)) dut_fz (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_fz)
    );

    imem_loader #(.ADDR_W(AW), .DATA_W(DW), .FILL_ZERO(1'b0)) dut_nf (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_nf)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_fz.start_o, bus_fz.busy_o, bus_fz.err_o, bus_fz.imem_we_o, bus_fz.s_ready_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_fz_ctrl got=%b want=00000",
                     {bus_fz.start_o, bus_fz.busy_o, bus_fz.err_o, bus_fz.imem_we_o, bus_fz.s_ready_o});
        end
        checks++;
        if ({bus_fz.imem_addr_o, bus_fz.imem_data_o} !== 40'h0) begin
            failures++;
            $display("FAIL reset_fz_bus got=%h/%h want=0/0", bus_fz.imem_addr_o, bus_fz.imem_data_o);
        end
        checks++;
        if ({bus_nf.start_o, bus_nf.busy_o, bus_nf.err_o, bus_nf.imem_we_o, bus_nf.s_ready_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_nf_ctrl got=%b want=00000",
                     {bus_nf.start_o, bus_nf.busy_o, bus_nf.err_o, bus_nf.imem_we_o, bus_nf.s_ready_o});
        end
        checks++;
        if ({bus_nf.imem_addr_o, bus_nf.imem_data_o} !== 40'h0) begin
            failures++;
            $display("FAIL reset_nf_bus got=%h/%h want=0/0", bus_nf.imem_addr_o, bus_nf.imem_data_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill_zero();
        logic [31:0] words [3];
        logic [7:0]  exp_addr;
        logic [31:0] exp_data;
        int nwr       = 0;
        int k         = 0;
        int last_wr   = -1;
        int start_cyc = -1;
        words[0] = 32'h0050_0093;
        words[1] = 32'h0010_0113;
        words[2] = 32'h0020_81b3;
        @(negedge clk);
        bus_fz.load_req_i = 1'b1;
        bus_fz.len_i      = 9'd3;
        for (int c = 0; c < 400 && start_cyc < 0; c++) begin
            @(negedge clk);
            bus_fz.load_req_i = 1'b0;
            if (bus_fz.imem_we_o) begin
                exp_addr = (nwr < DEPTH) ? 8'(nwr) : 8'(nwr - DEPTH);
                exp_data = (nwr < DEPTH) ? 32'h0 : ((nwr - DEPTH < 3) ? words[nwr - DEPTH] : 32'h0);
                checks++;
                if (nwr >= DEPTH + 3) begin
                    failures++;
                    $display("FAIL fz_extra_write got addr=%0d want=no write", bus_fz.imem_addr_o);
                end else if ({bus_fz.imem_addr_o, bus_fz.imem_data_o} !== {exp_addr, exp_data}) begin
                    failures++;
                    $display("FAIL fz_write[%0d] got=%0d:%h want=%0d:%h",
                             nwr, bus_fz.imem_addr_o, bus_fz.imem_data_o, exp_addr, exp_data);
                end
                if (nwr < DEPTH) begin
                    checks++;
                    if (bus_fz.s_ready_o !== 1'b0) begin
                        failures++;
                        $display("FAIL fz_ready_in_clear got=%b want=0", bus_fz.s_ready_o);
                    end
                end
                nwr++;
                last_wr = c;
            end
            if (bus_fz.start_o) begin
                start_cyc = c;
                checks++;
                if (bus_fz.busy_o !== 1'b0) begin
                    failures++;
                    $display("FAIL fz_busy_with_start got=%b want=0", bus_fz.busy_o);
                end
            end
            bus_fz.s_valid_i = 1'b1;
            bus_fz.s_data_i  = (k < 3) ? words[k] : 32'hFFFF_FFFF;
            if (bus_fz.s_ready_o) k++;
        end
        bus_fz.s_valid_i = 1'b0;
        checks++;
        if (nwr != DEPTH + 3) begin
            failures++;
            $display("FAIL fz_write_count got=%0d want=%0d", nwr, DEPTH + 3);
        end
        checks++;
        if (start_cyc < 0 || start_cyc != last_wr + 1) begin
            failures++;
            $display("FAIL fz_start_timing got=%0d want=%0d", start_cyc, last_wr + 1);
        end
    endtask

    task automatic test_len_reject();
        @(negedge clk);
        bus_nf.load_req_i = 1'b1;
        bus_nf.len_i      = 9'd257;
        @(negedge clk);
        bus_nf.load_req_i = 1'b0;
        checks++;
        if ({bus_nf.err_o, bus_nf.imem_we_o, bus_nf.start_o, bus_nf.busy_o} !== 4'b1000) begin
            failures++;
            $display("FAIL reject_err_pulse got=%b want=1000",
                     {bus_nf.err_o, bus_nf.imem_we_o, bus_nf.start_o, bus_nf.busy_o});
        end
        @(negedge clk);
        checks++;
        if ({bus_nf.err_o, bus_nf.imem_we_o, bus_nf.start_o, bus_nf.busy_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reject_stays_idle got=%b want=0000",
                     {bus_nf.err_o, bus_nf.imem_we_o, bus_nf.start_o, bus_nf.busy_o});
        end
        bus_nf.load_req_i = 1'b1;
        bus_nf.len_i      = 9'd0;
        @(negedge clk);
        bus_nf.load_req_i = 1'b0;
        checks++;
        if ({bus_nf.start_o, bus_nf.busy_o, bus_nf.imem_we_o, bus_nf.err_o} !== 4'b1000) begin
            failures++;
            $display("FAIL len0_direct_done got=%b want=1000",
                     {bus_nf.start_o, bus_nf.busy_o, bus_nf.imem_we_o, bus_nf.err_o});
        end
    endtask

    task automatic test_valid_toggle();
        logic [31:0] exp_data;
        int nwr       = 0;
        int k         = 0;
        int start_cyc = -1;
        bit prev_acc  = 1'b0;
        @(negedge clk);
        bus_nf.load_req_i = 1'b1;
        bus_nf.len_i      = 9'd4;
        for (int c = 0; c < 60 && start_cyc < 0; c++) begin
            @(negedge clk);
            bus_nf.load_req_i = 1'b0;
            if (c == 0) begin
                checks++;
                if ({bus_nf.start_o, bus_nf.busy_o} !== 2'b01) begin
                    failures++;
                    $display("FAIL toggle_start_drop got=%b want=01", {bus_nf.start_o, bus_nf.busy_o});
                end
            end
            checks++;
            if (bus_nf.imem_we_o !== prev_acc) begin
                failures++;
                $display("FAIL toggle_we_cycle%0d got=%b want=%b", c, bus_nf.imem_we_o, prev_acc);
            end
            if (bus_nf.imem_we_o) begin
                exp_data = 32'hA000_0000 + 32'(nwr);
                checks++;
                if ({bus_nf.imem_addr_o, bus_nf.imem_data_o} !== {8'(nwr), exp_data}) begin
                    failures++;
                    $display("FAIL toggle_write[%0d] got=%0d:%h want=%0d:%h",
                             nwr, bus_nf.imem_addr_o, bus_nf.imem_data_o, nwr, exp_data);
                end
                nwr++;
            end
            if (bus_nf.start_o) start_cyc = c;
            bus_nf.s_valid_i = (c % 2 == 0);
            bus_nf.s_data_i  = 32'hA000_0000 + 32'(k);
            prev_acc = bus_nf.s_valid_i && bus_nf.s_ready_o;
            if (prev_acc) k++;
        end
        bus_nf.s_valid_i = 1'b0;
        checks++;
        if (nwr != 4 || start_cyc < 0) begin
            failures++;
            $display("FAIL toggle_count got=%0d start_cyc=%0d want=4 with start", nwr, start_cyc);
        end
    endtask

    task automatic test_reset_abort();
        int nwr       = 0;
        int start_cyc = -1;
        @(negedge clk);
        bus_nf.load_req_i = 1'b1;
        bus_nf.len_i      = 9'd5;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus_nf.load_req_i = 1'b0;
            checks++;
            if (bus_nf.s_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL abort_ready_word%0d got=%b want=1", k, bus_nf.s_ready_o);
            end
            bus_nf.s_valid_i = 1'b1;
            bus_nf.s_data_i  = 32'hB000_0000 + 32'(k);
        end
        @(negedge clk);
        rst              = 1'b1;
        bus_nf.s_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_nf.start_o, bus_nf.busy_o, bus_nf.err_o, bus_nf.imem_we_o, bus_nf.s_ready_o} !== 5'b0 ||
            {bus_nf.imem_addr_o, bus_nf.imem_data_o} !== 40'h0) begin
            failures++;
            $display("FAIL abort_outputs_zero got=%b %h/%h want=00000 0/0",
                     {bus_nf.start_o, bus_nf.busy_o, bus_nf.err_o, bus_nf.imem_we_o, bus_nf.s_ready_o},
                     bus_nf.imem_addr_o, bus_nf.imem_data_o);
        end
        rst = 1'b0;
        @(negedge clk);
        bus_nf.load_req_i = 1'b1;
        bus_nf.len_i      = 9'd1;
        for (int c = 0; c < 20 && start_cyc < 0; c++) begin
            @(negedge clk);
            bus_nf.load_req_i = 1'b0;
            if (bus_nf.imem_we_o) begin
                checks++;
                if (nwr != 0 || {bus_nf.imem_addr_o, bus_nf.imem_data_o} !== {8'd0, 32'hDEAD_BEEF}) begin
                    failures++;
                    $display("FAIL abort_reload_write[%0d] got=%0d:%h want=0:deadbeef",
                             nwr, bus_nf.imem_addr_o, bus_nf.imem_data_o);
                end
                nwr++;
            end
            if (bus_nf.start_o) start_cyc = c;
            bus_nf.s_valid_i = 1'b1;
            bus_nf.s_data_i  = 32'hDEAD_BEEF;
        end
        bus_nf.s_valid_i = 1'b0;
        checks++;
        if (nwr != 1 || start_cyc < 0) begin
            failures++;
            $display("FAIL abort_reload_count got=%0d start_cyc=%0d want=1 with start", nwr, start_cyc);
        end
    endtask

    task automatic test_full_len();
        logic [31:0] exp_data;
        int nwr       = 0;
        int k         = 0;
        int first_acc = -1;
        int last_acc  = -1;
        int start_cyc = -1;
        bit rdy_done  = 1'b0;
        @(negedge clk);
        bus_nf.load_req_i = 1'b1;
        bus_nf.len_i      = 9'd256;
        for (int c = 0; c < 400 && start_cyc < 0; c++) begin
            @(negedge clk);
            bus_nf.load_req_i = 1'b0;
            if (bus_nf.imem_we_o) begin
                exp_data = 32'hC000_0000 + 32'(nwr);
                checks++;
                if (nwr >= DEPTH) begin
                    failures++;
                    $display("FAIL full_extra_write got addr=%0d want=no write", bus_nf.imem_addr_o);
                end else if ({bus_nf.imem_addr_o, bus_nf.imem_data_o} !== {8'(nwr), exp_data}) begin
                    failures++;
                    $display("FAIL full_write[%0d] got=%0d:%h want=%0d:%h",
                             nwr, bus_nf.imem_addr_o, bus_nf.imem_data_o, nwr, exp_data);
                end
                nwr++;
            end
            if (k == DEPTH && !rdy_done) begin
                rdy_done = 1'b1;
                checks++;
                if (bus_nf.s_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL full_ready_drop got=%b want=0", bus_nf.s_ready_o);
                end
            end
            if (bus_nf.start_o) start_cyc = c;
            bus_nf.s_valid_i = 1'b1;
            bus_nf.s_data_i  = 32'hC000_0000 + 32'(k);
            if (bus_nf.s_ready_o) begin
                if (first_acc < 0) first_acc = c;
                last_acc = c;
                k++;
            end
        end
        bus_nf.s_valid_i = 1'b0;
        checks++;
        if (nwr != DEPTH || start_cyc < 0) begin
            failures++;
            $display("FAIL full_count got=%0d start_cyc=%0d want=%0d with start", nwr, start_cyc, DEPTH);
        end
        checks++;
        if (last_acc - first_acc != DEPTH - 1) begin
            failures++;
            $display("FAIL full_back_to_back got span=%0d want=%0d", last_acc - first_acc, DEPTH - 1);
        end
    endtask

    task automatic test_req_ignored();
        int nwr       = 0;
        int start_cyc = -1;
        bit err_seen  = 1'b0;
        @(negedge clk);
        bus_nf.load_req_i = 1'b1;
        bus_nf.len_i      = 9'd2;
        for (int c = 0; c < 40 && start_cyc < 0; c++) begin
            @(negedge clk);
            bus_nf.load_req_i = (c == 1);
            bus_nf.len_i      = (c == 1) ? 9'd7 : 9'd2;
            if (bus_nf.err_o) err_seen = 1'b1;
            if (bus_nf.imem_we_o) begin
                checks++;
                if (bus_nf.imem_addr_o !== 8'(nwr) || nwr >= 2) begin
                    failures++;
                    $display("FAIL ignore_write[%0d] got addr=%0d want=%0d", nwr, bus_nf.imem_addr_o, nwr);
                end
                nwr++;
            end
            if (bus_nf.start_o) start_cyc = c;
            bus_nf.s_valid_i = 1'b1;
            bus_nf.s_data_i  = 32'h0000_0013;
        end
        bus_nf.s_valid_i  = 1'b0;
        bus_nf.load_req_i = 1'b0;
        checks++;
        if (nwr != 2 || start_cyc < 0 || err_seen) begin
            failures++;
            $display("FAIL ignore_len_kept got=%0d start_cyc=%0d err=%b want=2 with start, no err",
                     nwr, start_cyc, err_seen);
        end
        bus_nf.load_req_i = 1'b1;
        bus_nf.len_i      = 9'd300;
        @(negedge clk);
        bus_nf.load_req_i = 1'b0;
        checks++;
        if ({bus_nf.err_o, bus_nf.start_o, bus_nf.busy_o} !== 3'b110) begin
            failures++;
            $display("FAIL done_reject got=%b want=110", {bus_nf.err_o, bus_nf.start_o, bus_nf.busy_o});
        end
        @(negedge clk);
        bus_nf.load_req_i = 1'b1;
        bus_nf.len_i      = 9'd1;
        @(negedge clk);
        bus_nf.load_req_i = 1'b0;
        checks++;
        if ({bus_nf.err_o, bus_nf.start_o, bus_nf.busy_o} !== 3'b001) begin
            failures++;
            $display("FAIL done_restart got=%b want=001", {bus_nf.err_o, bus_nf.start_o, bus_nf.busy_o});
        end
        start_cyc = -1;
        for (int c = 0; c < 20 && start_cyc < 0; c++) begin
            bus_nf.s_valid_i = 1'b1;
            bus_nf.s_data_i  = 32'h0000_0013;
            @(negedge clk);
            if (bus_nf.start_o) start_cyc = c;
        end
        bus_nf.s_valid_i = 1'b0;
        checks++;
        if (start_cyc < 0) begin
            failures++;
            $display("FAIL restart_completes got=no start want=start");
        end
    endtask

    initial begin
        bus_fz.load_req_i = 1'b0;
        bus_fz.len_i      = '0;
        bus_fz.s_valid_i  = 1'b0;
        bus_fz.s_data_i   = '0;
        bus_nf.load_req_i = 1'b0;
        bus_nf.len_i      = '0;
        bus_nf.s_valid_i  = 1'b0;
        bus_nf.s_data_i   = '0;
        test_reset();
        test_fill_zero();
        test_len_reject();
        test_valid_toggle();
        test_reset_abort();
        test_full_len();
        test_req_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
